// File: rtl/vga_pattern_pkg.sv
// vga_pattern_pkg: mode encodings, bar palette and colour helpers shared by the VGA pattern generator.
package vga_pattern_pkg;

    localparam logic [2:0] PAT_BARS   = 3'd0;
    localparam logic [2:0] PAT_CHECK  = 3'd1;
    localparam logic [2:0] PAT_GRAD   = 3'd2;
    localparam logic [2:0] PAT_SOLID  = 3'd3;
    localparam logic [2:0] PAT_BORDER = 3'd4;

    typedef enum logic {
        TRK_SYNC,
        TRK_RUN
    } trk_state_e;

    // Entry 0 is the rightmost element: FFF,CCC,888,000,F00,800,FF0,880,0F0,080,0FF,088,00F,008,F0F,808
    localparam logic [15:0][11:0] PALETTE = {
        12'h808, 12'hF0F, 12'h008, 12'h00F,
        12'h088, 12'h0FF, 12'h080, 12'h0F0,
        12'h880, 12'hFF0, 12'h800, 12'hF00,
        12'h000, 12'h888, 12'hCCC, 12'hFFF
    };

    // Left-aligned 8-bit replication; callers keep the top COLOR_DEPTH bits.
    function automatic logic [7:0] widen_nibble(input logic [3:0] n);
        return {n, n};
    endfunction

endpackage

// File: rtl/vga_pixel_tracker.sv
// vga_pixel_tracker: pixel X/Y and frame counters plus the SYNC/RUN lock-on to the frame boundary.
module vga_pixel_tracker
    import vga_pattern_pkg::*;
#(
    parameter int RES_W = 12
) (
    input  logic             pxl_clk,
    input  logic             pxl_rst,
    input  logic             vert_active,
    input  logic             frame_active,
    output logic [RES_W-1:0] x,
    output logic [RES_W-1:0] y,
    output logic [7:0]       frame_cnt,
    output logic             sof_pulse,
    output logic             in_run
);

    trk_state_e       state_q, state_d;
    logic             vert_q, fa_q;
    logic [RES_W-1:0] x_q, x_d, y_q, y_d;
    logic [7:0]       fc_q, fc_d;
    logic             vert_fall, fa_fall, cnt_en;

    assign vert_fall = vert_q & ~vert_active;
    assign fa_fall   = fa_q & ~frame_active;
    // The boundary that leaves SYNC already counts as the first frame edge.
    assign cnt_en    = (state_q == TRK_RUN) | vert_fall;

    always_ff @(posedge pxl_clk) begin
        if (pxl_rst) begin
            state_q <= TRK_SYNC;
            vert_q  <= 1'b0;
            fa_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            vert_q  <= vert_active;
            fa_q    <= frame_active;
            x_q     <= x_d;
            y_q     <= y_d;
            fc_q    <= fc_d;
        end
    end

    always_comb begin
        state_d = (state_q == TRK_SYNC && vert_fall) ? TRK_RUN : state_q;
        x_d     = (cnt_en && frame_active) ? x_q + 1'b1 : '0;
        y_d     = (!cnt_en || vert_fall) ? '0 : fa_fall ? y_q + 1'b1 : y_q;
        fc_d    = !cnt_en ? '0 : vert_fall ? fc_q + 8'd1 : fc_q;
    end

    assign x         = x_q;
    assign y         = y_q;
    assign frame_cnt = fc_q;
    assign sof_pulse = vert_fall;
    assign in_run    = state_q == TRK_RUN;

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: multi-mode VGA test pattern generator with one registered pixel of latency.
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int COLOR_DEPTH = 4,
    parameter int RES_W       = 12,
    parameter int BAR_LOG2    = 4,
    parameter int CHECK_LOG2  = 5
) (
    input  logic                     pxl_clk,
    input  logic                     pxl_rst,
    input  logic [RES_W-1:0]         horz_res,
    input  logic [RES_W-1:0]         vert_res,
    input  logic                     horz_active,
    input  logic                     vert_active,
    input  logic                     frame_active,
    input  logic [2:0]               pattern_sel,
    input  logic [3*COLOR_DEPTH-1:0] solid_rgb,
    output logic [COLOR_DEPTH-1:0]   rgb_red,
    output logic [COLOR_DEPTH-1:0]   rgb_green,
    output logic [COLOR_DEPTH-1:0]   rgb_blue,
    output logic                     rgb_valid
);

    localparam int CW = 3 * COLOR_DEPTH;

    logic [RES_W-1:0]    x, y, bar_w, bar_cnt_q, bar_cnt_d;
    logic [7:0]          frame_cnt;
    logic                sof_pulse, in_run, pix_on, bar_end, border;
    logic [BAR_LOG2-1:0] bar_idx_q, bar_idx_d;
    logic [3:0]          pal_idx;
    logic [11:0]         pal;
    logic [7:0]          wr, wg, wb;
    logic [2:0]          mode_q, mode_d;
    logic [CW-1:0]       solid_q, solid_d, rgb_q, rgb_d;
    logic                valid_q, valid_d;
    logic                unused_inputs;

    vga_pixel_tracker #(.RES_W(RES_W)) u_tracker (
        .pxl_clk      (pxl_clk),
        .pxl_rst      (pxl_rst),
        .vert_active  (vert_active),
        .frame_active (frame_active),
        .x            (x),
        .y            (y),
        .frame_cnt    (frame_cnt),
        .sof_pulse    (sof_pulse),
        .in_run       (in_run)
    );

    assign unused_inputs = ^{horz_active, frame_cnt};

    assign pix_on  = in_run & frame_active;
    assign bar_w   = horz_res >> BAR_LOG2;
    assign bar_end = bar_cnt_q == bar_w - 1'b1;
    // A zero bar width would underflow the compare, so the whole line stays on entry 0.
    assign pal_idx = (bar_w == '0) ? 4'd0 : 4'(bar_idx_q) << (4 - BAR_LOG2);
    assign pal     = PALETTE[pal_idx];
    assign wr      = widen_nibble(pal[11:8]);
    assign wg      = widen_nibble(pal[7:4]);
    assign wb      = widen_nibble(pal[3:0]);
    assign border  = x == '0 || x == horz_res - 1'b1 || y == '0 || y == vert_res - 1'b1;

    always_comb begin
        bar_cnt_d = '0;
        bar_idx_d = '0;
        if (pix_on) begin
            bar_cnt_d = bar_end ? '0 : bar_cnt_q + 1'b1;
            bar_idx_d = (bar_end && bar_idx_q != '1) ? bar_idx_q + 1'b1 : bar_idx_q;
        end
    end

    always_comb begin
        mode_d  = sof_pulse ? pattern_sel : mode_q;
        solid_d = sof_pulse ? solid_rgb : solid_q;
        valid_d = pix_on;
        rgb_d   = '0;
        if (pix_on) begin
            if (mode_q == PAT_BARS)
                rgb_d = {wr[7 -: COLOR_DEPTH], wg[7 -: COLOR_DEPTH], wb[7 -: COLOR_DEPTH]};
            else if (mode_q == PAT_CHECK)
                rgb_d = {CW{~(x[CHECK_LOG2] ^ y[CHECK_LOG2])}};
            else if (mode_q == PAT_GRAD)
                rgb_d = {x[COLOR_DEPTH+1:2], y[COLOR_DEPTH+1:2], frame_cnt[7 -: COLOR_DEPTH]};
            else if (mode_q == PAT_SOLID)
                rgb_d = solid_q;
            else if (mode_q == PAT_BORDER)
                rgb_d = {CW{border}};
        end
    end

    always_ff @(posedge pxl_clk) begin
        if (pxl_rst) begin
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            mode_q    <= PAT_BARS;
            solid_q   <= '0;
            rgb_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            mode_q    <= mode_d;
            solid_q   <= solid_d;
            rgb_q     <= rgb_d;
            valid_q   <= valid_d;
        end
    end

    assign {rgb_red, rgb_green, rgb_blue} = rgb_q;
    assign rgb_valid = valid_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: random frame timing driven into 4-bit and 8-bit generators,
// checked pixel by pixel against a coordinate-based colour model.
module tb_vga_pattern_gen;

    logic        pxl_clk = 1'b0;
    logic        pxl_rst = 1'b1;
    logic [11:0] horz_res = '0, vert_res = '0;
    logic        horz_active = 1'b0, vert_active = 1'b0, frame_active = 1'b0;
    logic [2:0]  pattern_sel = '0;
    logic [23:0] sol = '0;
    logic [3:0]  r4, g4, b4;
    logic [7:0]  r8, g8, b8;
    logic        v4, v8;
    int          errors = 0, checks = 0;

    bit          running, prev_v;
    int          fc;
    logic [2:0]  m_mode;
    logic [23:0] m_sol;

    int PAL [16] = '{'hFFF, 'hCCC, 'h888, 'h000, 'hF00, 'h800, 'hFF0, 'h880,
                     'h0F0, 'h080, 'h0FF, 'h088, 'h00F, 'h008, 'hF0F, 'h808};

    always #5 pxl_clk = ~pxl_clk;

    vga_pattern_gen #(.COLOR_DEPTH(4), .RES_W(12), .BAR_LOG2(4), .CHECK_LOG2(3)) dut4 (
        .pxl_clk(pxl_clk), .pxl_rst(pxl_rst), .horz_res(horz_res), .vert_res(vert_res),
        .horz_active(horz_active), .vert_active(vert_active), .frame_active(frame_active),
        .pattern_sel(pattern_sel), .solid_rgb(sol[11:0]),
        .rgb_red(r4), .rgb_green(g4), .rgb_blue(b4), .rgb_valid(v4)
    );

    vga_pattern_gen #(.COLOR_DEPTH(8), .RES_W(12), .BAR_LOG2(4), .CHECK_LOG2(1)) dut8 (
        .pxl_clk(pxl_clk), .pxl_rst(pxl_rst), .horz_res(horz_res), .vert_res(vert_res),
        .horz_active(horz_active), .vert_active(vert_active), .frame_active(frame_active),
        .pattern_sel(pattern_sel), .solid_rgb(sol),
        .rgb_red(r8), .rgb_green(g8), .rgb_blue(b8), .rgb_valid(v8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {R,G,B} (8-bit fields, cd bits used) for pixel (x,y) of the latched mode.
    function automatic logic [23:0] model_px(input int cd, input int bl, input int cl, input int x, input int y);
        int mask, bw, idx, p, r, g, b;
        mask = (1 << cd) - 1;
        r = 0; g = 0; b = 0;
        case (m_mode)
            3'd0: begin
                bw  = int'(horz_res) >> bl;
                idx = (bw == 0) ? 0 : x / bw;
                if (idx > (1 << bl) - 1) idx = (1 << bl) - 1;
                p = PAL[idx << (4 - bl)];
                r = (((p >> 8) & 15) * 17) >> (8 - cd);
                g = (((p >> 4) & 15) * 17) >> (8 - cd);
                b = ((p & 15) * 17) >> (8 - cd);
            end
            3'd1: begin
                r = ((((x >> cl) ^ (y >> cl)) & 1) == 0) ? mask : 0;
                g = r; b = r;
            end
            3'd2: begin
                r = (x >> 2) & mask;
                g = (y >> 2) & mask;
                b = fc >> (8 - cd);
            end
            3'd3: begin
                r = int'(m_sol >> (2 * cd)) & mask;
                g = int'(m_sol >> cd) & mask;
                b = int'(m_sol) & mask;
            end
            3'd4: begin
                r = (x == 0 || x == int'(horz_res) - 1 || y == 0 || y == int'(vert_res) - 1) ? mask : 0;
                g = r; b = r;
            end
            default: ;
        endcase
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    task automatic cycle(input bit ha, input bit va, input bit rst, input int x, input int y);
        logic [23:0] e4, e8;
        bit on;
        horz_active  = ha;
        vert_active  = va;
        frame_active = ha & va;
        pxl_rst      = rst;
        on = !rst && running && ha && va;
        e4 = on ? model_px(4, 4, 3, x, y) : 24'd0;
        e8 = on ? model_px(8, 4, 1, x, y) : 24'd0;
        @(posedge pxl_clk);
        #1;
        check("px4", {7'd0, v4, 12'd0, r4, g4, b4}, {7'd0, on, 12'd0, e4[19:16], e4[11:8], e4[3:0]});
        check("px8", {7'd0, v8, r8, g8, b8}, {7'd0, on, e8});
        if (rst) begin
            running = 0; fc = 0; m_mode = '0; m_sol = '0; prev_v = 0;
        end else begin
            if (prev_v && !va) begin
                running = 1;
                fc      = (fc + 1) % 256;
                m_mode  = pattern_sel;
                m_sol   = sol;
            end
            prev_v = va;
        end
    endtask

    // nsel/nsol < 0 pick random values; early drops vert_active together with the last line's frame_active.
    task automatic frame(input int hres, input int vres, input int hbl, input int vbl,
                         input bit early, input int nsel, input int nsol, input int rst_line);
        int chg;
        bit va;
        chg = int'($urandom_range(vres - 1, 0));
        horz_res = 12'(hres);
        vert_res = 12'(vres);
        for (int l = 0; l < vres + vbl; l++)
            for (int p = 0; p < hres + hbl; p++) begin
                va = (l < vres - 1) || (l == vres - 1 && !(early && p >= hres));
                if (l == chg && p == 0) begin
                    pattern_sel = (nsel < 0) ? 3'($urandom_range(7)) : 3'(nsel);
                    sol = (nsol < 0) ? 24'($urandom) : 24'(nsol);
                end
                cycle(p < hres, va, l == rst_line && p == 3, p, l);
            end
    endtask

    initial begin
        running = 0; prev_v = 0; fc = 0; m_mode = '0; m_sol = '0;
        repeat (3) @(posedge pxl_clk);
        #1;
        check("rst4", {7'd0, v4, 12'd0, r4, g4, b4}, 32'd0);
        check("rst8", {7'd0, v8, r8, g8, b8}, 32'd0);
        frame(640, 2, 10, 2, 0, 0, -1, -1);
        frame(640, 2, 10, 2, 0, 4, -1, -1);
        frame(640, 4, 10, 2, 1, 0, -1, -1);
        frame(650, 2, 6, 1, 0, 0, -1, -1);
        frame(650, 2, 6, 1, 1, -1, -1, -1);
        for (int i = 0; i < 24; i++)
            frame(int'($urandom_range(90, 1)), int'($urandom_range(10, 1)), int'($urandom_range(6, 1)),
                  int'($urandom_range(3, 1)), 1'($urandom_range(1)), -1, -1, -1);
        frame(40, 8, 4, 2, 0, 2, -1, 4);
        for (int i = 0; i < 300; i++)
            frame(6, 3, 2, 1, i[0], 2, -1, -1);
        frame(20, 4, 3, 1, 0, 3, 'h5A3, -1);
        frame(20, 4, 3, 1, 1, 3, 'h5A3, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
